// File: rtl/ula_arbiter.sv
// Two-requester arbiter sharing one external combinational ULA: IDLE -> EXEC -> RESP.
// Define ULA_ARBITER_RR_EN for round-robin on ties; otherwise requester 0 has fixed priority.
`timescale 1ns/1ps
module ula_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [0:WIDTH-1] req0_a,
  input  logic [0:WIDTH-1] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [0:WIDTH-1] req1_a,
  input  logic [0:WIDTH-1] req1_b,
  output logic [3:0]       ula_op,
  output logic [0:WIDTH-1] ula_a,
  output logic [0:WIDTH-1] ula_b,
  input  logic [0:WIDTH-1] ula_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [0:WIDTH-1] rsp_data,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   last_id;
  logic   grant_id;
  logic   accept;

  function automatic logic op_illegal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111: op_illegal = 1'b0;
      default:                                     op_illegal = 1'b1;
    endcase
  endfunction

  // A lone requester always wins; only a tie consults the policy.
  always_comb begin
    if (req0_valid && req1_valid) begin
`ifdef ULA_ARBITER_RR_EN
      grant_id = ~last_id;
`else
      grant_id = 1'b0;
`endif
    end else begin
      grant_id = ~req0_valid;
    end
  end

  // Readies are gated by reset so nothing looks accepted while the block is held.
  assign accept     = ~reset && (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;
  assign busy       = (state != IDLE);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last_id   <= 1'b1;
      ula_op    <= 4'b0000;
      ula_a     <= '0;
      ula_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            last_id <= grant_id;
            ula_op  <= grant_id ? req1_op : req0_op;
            ula_a   <= grant_id ? req1_a  : req0_a;
            ula_b   <= grant_id ? req1_b  : req0_b;
            state   <= EXEC;
          end
        end
        EXEC: begin
          // last_id still names the requester whose operation is on the ULA.
          rsp_id    <= last_id;
          rsp_data  <= ula_result;
          rsp_err   <= op_illegal(ula_op);
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_arbiter.sv
// Self-checking bench for ula_arbiter: transaction-level reference model plus directed and random traffic.
`timescale 1ns/1ps
module tb_ula_arbiter;
  localparam int W = 32;
`ifdef ULA_ARBITER_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  typedef struct {
    logic [3:0]   op;
    logic [0:W-1] a;
    logic [0:W-1] b;
  } op_t;

  typedef struct {
    logic         id;
    logic [0:W-1] data;
    logic         err;
  } rsp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]   req0_op, req1_op, ula_op;
  logic [0:W-1] req0_a, req0_b, req1_a, req1_b, ula_a, ula_b, ula_result;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [0:W-1] rsp_data;

  ula_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .ula_op(ula_op), .ula_a(ula_a), .ula_b(ula_b), .ula_result(ula_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behaviour of the shared ULA; codes outside the legal set still produce a value.
  function automatic logic [0:W-1] ula_fn(input logic [3:0] op, input logic [0:W-1] a, input logic [0:W-1] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      4'b1111: return ~(a | b);
      default: return a ^ b;
    endcase
  endfunction

  assign ula_result = ula_fn(ula_op, ula_a, ula_b);

  function automatic logic is_illegal(input logic [3:0] op);
    return !(op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111});
  endfunction

  function automatic op_t mk(input logic [3:0] op, input logic [0:W-1] a, input logic [0:W-1] b);
    op_t t;
    t.op = op;
    t.a  = a;
    t.b  = b;
    return t;
  endfunction

  int   checks = 0;
  int   failures = 0;
  op_t  q0[$];
  op_t  q1[$];
  rsp_t log_q[$];

  // Reference model state: one outstanding transaction and the cycles since it was accepted.
  bit           pend;
  int           age;
  logic         model_last;
  logic         exp_id;
  logic [0:W-1] exp_data;
  logic         exp_err;
  logic [3:0]   last_op;
  logic [0:W-1] last_a, last_b;
  int           hold_left;
  bit           rand_rdy;
  bit           gap_en;

  function automatic int pick(input bit v0, input bit v1);
    if (v0 && v1) return (RR_MODE && !model_last) ? 1 : 0;
    return v0 ? 0 : 1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_op    = 4'($urandom);
    req1_op    = 4'($urandom);
    rsp_ready  = 1'b1;
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_ula_op", ula_op, 0);
    check("rst_ula_a", ula_a, 0);
    check("rst_ula_b", ula_b, 0);
    check("rst_busy", busy, 0);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    pend       = 1'b0;
    age        = 0;
    model_last = 1'b1;
    last_op    = '0;
    last_a     = '0;
    last_b     = '0;
    @(posedge clk);
    #2;
    reset      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // One clock of traffic: check outputs, drive inputs, predict the coming edge.
  task automatic cycle();
    bit   v0, v1;
    int   w;
    op_t  cur;
    rsp_t r;
    @(negedge clk);
    if (pend) age++;
    check("busy", busy, pend);
    check("rsp_valid", rsp_valid, pend && age >= 2);
    if (pend && age >= 2) begin
      check("rsp_id", rsp_id, exp_id);
      check("rsp_data", rsp_data, exp_data);
      check("rsp_err", rsp_err, exp_err);
    end
    check("ula_op", ula_op, last_op);
    check("ula_a", ula_a, last_a);
    check("ula_b", ula_b, last_b);

    v0 = (q0.size() > 0) && (!gap_en || $urandom_range(0, 3) != 0);
    v1 = (q1.size() > 0) && (!gap_en || $urandom_range(0, 3) != 0);
    req0_valid = v0;
    req1_valid = v1;
    if (v0) begin
      req0_op = q0[0].op; req0_a = q0[0].a; req0_b = q0[0].b;
    end else begin
      req0_op = 4'($urandom); req0_a = $urandom; req0_b = $urandom;
    end
    if (v1) begin
      req1_op = q1[0].op; req1_a = q1[0].a; req1_b = q1[0].b;
    end else begin
      req1_op = 4'($urandom); req1_a = $urandom; req1_b = $urandom;
    end
    if (pend && age >= 2 && hold_left > 0) begin
      rsp_ready = 1'b0;
      hold_left--;
    end else begin
      rsp_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    #1;

    if (!pend && (v0 || v1)) begin
      w = pick(v0, v1);
      check("req0_ready", req0_ready, w == 0);
      check("req1_ready", req1_ready, w == 1);
      cur        = (w == 0) ? q0.pop_front() : q1.pop_front();
      pend       = 1'b1;
      age        = 0;
      model_last = w[0];
      exp_id     = w[0];
      exp_data   = ula_fn(cur.op, cur.a, cur.b);
      exp_err    = is_illegal(cur.op);
      last_op    = cur.op;
      last_a     = cur.a;
      last_b     = cur.b;
    end else begin
      check("req0_ready_idle", req0_ready, 0);
      check("req1_ready_idle", req1_ready, 0);
      if (pend && age >= 2 && rsp_ready) begin
        r.id   = rsp_id;
        r.data = rsp_data;
        r.err  = rsp_err;
        log_q.push_back(r);
        pend = 1'b0;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || pend) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_budget", n < budget, 1);
  endtask

  task automatic check_log(input string tag, input int idx, input logic id, input logic [0:W-1] data);
    if (idx < log_q.size()) begin
      check({tag, "_id"}, log_q[idx].id, id);
      check({tag, "_data"}, log_q[idx].data, data);
    end else begin
      check({tag, "_present"}, 0, 1);
    end
  endtask

  logic [3:0] legal_ops [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111};

  initial begin
    reset = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_op = 0; req0_a = 0; req0_b = 0;
    req1_op = 0; req1_a = 0; req1_b = 0;
    hold_left = 0; rand_rdy = 0; gap_en = 0;
    #1;
    do_reset();

    // Single add from requester 0.
    log_q.delete();
    q0.push_back(mk(4'b0010, 3, 3));
    drain(20);
    check("add_count", log_q.size(), 1);
    check_log("add", 0, 1'b0, 6);

    // Lone requester 1, then a tie.
    log_q.delete();
    q1.push_back(mk(4'b0110, 3, 1));
    drain(20);
    q0.push_back(mk(4'b0000, 3, 1));
    q1.push_back(mk(4'b0001, 3, 1));
    drain(30);
    check("tie_count", log_q.size(), 3);
    check_log("tie0", 0, 1'b1, 2);
    check_log("tie1", 1, 1'b0, 1);
    check_log("tie2", 2, 1'b1, 3);

    // Both requesters continuously valid, four operations each.
    do_reset();
    log_q.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(4'b0010, W'(i), 100));
      q1.push_back(mk(4'b0010, W'(i), 200));
    end
    drain(100);
    check("stream_count", log_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < log_q.size())
        check("stream_order", log_q[i].id, RR_MODE ? (i % 2) : (i >= 4));
    end

    // Response back-pressure with requester 1 waiting.
    log_q.delete();
    hold_left = 3;
    q0.push_back(mk(4'b0111, 1, 3));
    q1.push_back(mk(4'b0010, 5, 5));
    drain(30);
    check("hold_count", log_q.size(), 2);
    check_log("hold0", 0, 1'b0, 1);
    check_log("hold1", 1, 1'b1, 10);

    // Illegal opcode.
    log_q.delete();
    q1.push_back(mk(4'b1111, 5, 2));
    drain(20);
    check("illegal_count", log_q.size(), 1);
    check_log("illegal", 0, 1'b1, ~W'(7));
    if (log_q.size() > 0) check("illegal_err", log_q[0].err, 1);

    // Reset while the operation is in EXEC.
    log_q.delete();
    q0.push_back(mk(4'b0010, 7, 1));
    cycle();
    cycle();
    do_reset();
    repeat (4) cycle();
    check("abort_count", log_q.size(), 0);
    q1.push_back(mk(4'b0010, 2, 2));
    drain(20);
    check("after_abort_count", log_q.size(), 1);
    check_log("after_abort", 0, 1'b1, 4);

    // Random traffic with gaps and random back-pressure.
    rand_rdy = 1;
    gap_en   = 1;
    for (int i = 0; i < 30; i++) begin
      q0.push_back(mk($urandom_range(0, 1) ? legal_ops[$urandom_range(0, 4)] : 4'($urandom), $urandom, $urandom));
      q1.push_back(mk($urandom_range(0, 1) ? legal_ops[$urandom_range(0, 4)] : 4'($urandom), $urandom, $urandom));
    end
    drain(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ula_arbiter.md
ULA_ARBITER -- requirements
Module: ula_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; all data ports are [0:WIDTH-1].
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  arbiter accepts requester 0 this cycle.
REQ-006 req0_op / req0_a / req0_b  input  4 / WIDTH / WIDTH  requester 0 ALU opcode and operands.
REQ-007 req1_valid, req1_ready, req1_op, req1_a, req1_b  same as REQ-004..006 for requester 1.
REQ-008 ula_op / ula_a / ula_b  output  4 / WIDTH / WIDTH  registered drive to the shared ULA inputULA/a/b.
REQ-009 ula_result  input  WIDTH  ULA outputULA, combinational from ula_op/ula_a/ula_b.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  consumer takes result this cycle.
REQ-012 rsp_id / rsp_data / rsp_err  output  1 / WIDTH / 1  originating requester, ALU result, illegal-opcode flag.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, EXEC, RESP; no other reachable states.
REQ-015 IDLE: reqN_ready SHALL be high only for the granted requester N, and only while reqN_valid is high; both readies never high together.
REQ-016 Handshake: transfer occurs on reqN_valid & reqN_ready; on transfer, op/a/b/id SHALL be registered and FSM SHALL go IDLE->EXEC.
REQ-017 EXEC (one cycle): ula_op/ula_a/ula_b SHALL hold the registered request; at end of cycle ula_result SHALL be captured into rsp_data and FSM SHALL go EXEC->RESP.
REQ-018 RESP: rsp_valid SHALL be high; rsp_id/rsp_data/rsp_err SHALL be stable until rsp_valid & rsp_ready, then FSM SHALL go RESP->IDLE.
REQ-019 Latency: accept at cycle N -> rsp_valid high at cycle N+2; earliest next accept at cycle N+3 (rsp_ready high at N+2).
REQ-020 No request SHALL be accepted in EXEC or RESP; both readies low there.
REQ-021 rsp_err SHALL be 1 when registered op is not one of 0000 (and), 0001 (or), 0010 (add), 0110 (sub), 0111 (slt); operation still executes and rsp_data carries ula_result.
REQ-022 Grant pointer last_id (1 bit) SHALL update to the accepted requester's id on every transfer.
REQ-023 Single valid requester in IDLE SHALL be granted regardless of last_id.
REQ-024 rsp_ready high while rsp_valid low SHALL have no effect.
REQ-025 ula_op/ula_a/ula_b SHALL hold their last values outside EXEC (no toggling when idle).

Reset
REQ-026 Assertion of reset SHALL asynchronously force: state IDLE, rsp_valid 0, rsp_id 0, rsp_data 0, rsp_err 0, ula_op 0000, ula_a 0, ula_b 0, last_id 1, busy 0, both readies 0.
REQ-027 Reset in EXEC or RESP SHALL abort the operation; no response for it is ever produced.
REQ-028 First cycle after reset release SHALL be IDLE and able to accept.

Configuration
REQ-029 Macro ULA_ARBITER_RR_EN defined: both valid in IDLE -> grant requester != last_id (round-robin).
REQ-030 Macro ULA_ARBITER_RR_EN undefined: both valid in IDLE -> requester 0 always granted (fixed priority); last_id still maintained but unused for arbitration.

Verification
REQ-031 req0 op=0010 a=3 b=3, rsp_ready=1 -> req0_ready at N, rsp_valid at N+2, rsp_id=0, rsp_data=6, rsp_err=0.
REQ-032 req1 alone op=0110 a=3 b=1, then req0 op=0000 a=3 b=1 and req1 op=0001 a=3 b=1 together -> with RR_EN: responses (id1,2),(id0,1),(id1,3); without: (id1,2),(id0,1),(id1,3) with req0 granted first in the tie.
REQ-033 Both valid continuously, 4 ops each, RR_EN defined -> grants alternate 0,1,0,1...; undefined -> all four req0 ops complete before any further req1.
REQ-034 req0 op=0111 a=1 b=3, rsp_ready low 3 cycles -> rsp_valid and rsp_data=1 held 3 cycles, both readies low, busy high; completes when rsp_ready rises.
REQ-035 req1 op=1111 a=5 b=2 -> rsp_err=1, rsp_id=1, rsp_data equals ULA output for 1111.
REQ-036 reset pulsed while in EXEC for req0 add 7+1 -> rsp_valid never rises for it, all outputs at REQ-026 values, next req1 add 2+2 returns rsp_data=4 at N+2.
